// File: rtl/lsu_store_buf_pkg.sv
// Shared definitions for the LSU store buffer: one-hot access size codes,
// the byte-lane mask table and the doubleword offset width.
package lsu_store_buf_pkg;

   localparam logic [3:0] SZ_B = 4'b0001;
   localparam logic [3:0] SZ_H = 4'b0010;
   localparam logic [3:0] SZ_W = 4'b0100;
   localparam logic [3:0] SZ_D = 4'b1000;

   localparam int DW_OFF_W = 3;

   // Byte-lane mask of an access placed at offset 0; zero for illegal size codes.
   function automatic logic [7:0] lane_mask(input logic [3:0] size);
      case (size)
         SZ_B:    lane_mask = 8'h01;
         SZ_H:    lane_mask = 8'h03;
         SZ_W:    lane_mask = 8'h0F;
         SZ_D:    lane_mask = 8'hFF;
         default: lane_mask = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_st_align.sv
// Combinational lane alignment: size + doubleword offset + data ->
// byte mask, lane-replicated data, and a misalign flag (also set for
// non-one-hot size codes).
module lsu_st_align
   import lsu_store_buf_pkg::*;
(
   input  logic [3:0]          size,
   input  logic [DW_OFF_W-1:0] off,
   input  logic [63:0]         data,
   output logic [7:0]          mask,
   output logic [63:0]         wdata,
   output logic                misalign
);

   // Build mask from the size table, replicate the low-order data across the lane.
   always_comb begin
      mask     = lane_mask(size) << off;
      wdata    = '0;
      misalign = 1'b0;
      case (size)
         SZ_B: wdata = {8{data[7:0]}};
         SZ_H: begin
            wdata    = {4{data[15:0]}};
            misalign = off[0];
         end
         SZ_W: begin
            wdata    = {2{data[31:0]}};
            misalign = |off[1:0];
         end
         SZ_D: begin
            wdata    = data;
            misalign = |off;
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_store_buf.sv
// LSU store buffer: aligns committed stores to 64-bit SRAM lanes, queues
// them in a strict FIFO and drains to the data SRAM whenever no load holds
// the port. Flags load/store byte overlap as a hazard.
// Optional store-to-load forwarding is enabled by defining LSU_STORE_FWD_EN.
module lsu_store_buf
   import lsu_store_buf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [63:0]       st_data,
   input  logic [3:0]        st_size,
   output logic              st_misalign,
   input  logic              ld_busy,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [3:0]        ld_size,
   output logic              ld_hazard,
   output logic              ld_fwd_valid,
   output logic [63:0]       ld_fwd_data,
   output logic              data_sram_en,
   output logic [7:0]        data_sram_we,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [63:0]       data_sram_wdata,
   input  logic              data_sram_ready,
   output logic              sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DWA_W = ADDR_W - DW_OFF_W;

   logic [DWA_W-1:0] addr_q  [DEPTH];
   logic [DWA_W-1:0] addr_d  [DEPTH];
   logic [7:0]       mask_q  [DEPTH];
   logic [7:0]       mask_d  [DEPTH];
   logic [63:0]      wdata_q [DEPTH];
   logic [63:0]      wdata_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mis_q, mis_d;

   logic [7:0]       st_mask, ld_mask;
   logic [63:0]      st_wdata, ld_lane_unused;
   logic             st_mis, ld_mis_unused;
   logic             full, empty, enq, deq;
   logic [DEPTH-1:0] hit;

   lsu_st_align u_st_align (
      .size     (st_size),
      .off      (st_addr[DW_OFF_W-1:0]),
      .data     (st_data),
      .mask     (st_mask),
      .wdata    (st_wdata),
      .misalign (st_mis)
   );

   // Only the byte mask of the load is needed; its data input is tied off.
   lsu_st_align u_ld_align (
      .size     (ld_size),
      .off      (ld_addr[DW_OFF_W-1:0]),
      .data     (64'd0),
      .mask     (ld_mask),
      .wdata    (ld_lane_unused),
      .misalign (ld_mis_unused)
   );

   assign full        = (cnt_q == CNT_W'(DEPTH));
   assign empty       = (cnt_q == '0);
   assign st_ready    = !full;
   assign sb_empty    = empty;
   assign st_misalign = mis_q;
   assign enq         = st_valid & st_ready & !st_mis;

   // Loads own the SRAM port; head entry is presented straight from its registers.
   assign data_sram_en    = !empty & !ld_busy;
   assign deq             = data_sram_en & data_sram_ready;
   assign data_sram_we    = data_sram_en ? mask_q[rd_ptr_q] : '0;
   assign data_sram_addr  = data_sram_en ? {addr_q[rd_ptr_q], {DW_OFF_W{1'b0}}} : '0;
   assign data_sram_wdata = data_sram_en ? wdata_q[rd_ptr_q] : '0;

   // FIFO next state: dequeue retires the head, enqueue fills the tail.
   always_comb begin
      addr_d   = addr_q;
      mask_d   = mask_q;
      wdata_d  = wdata_q;
      vld_d    = vld_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      mis_d    = st_valid & st_mis;
      if (deq) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      if (enq) begin
         vld_d[wr_ptr_q]   = 1'b1;
         addr_d[wr_ptr_q]  = st_addr[ADDR_W-1:DW_OFF_W];
         mask_d[wr_ptr_q]  = st_mask;
         wdata_d[wr_ptr_q] = st_wdata;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers with synchronous reset discarding all buffered stores.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            mask_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         mis_q    <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         mask_q   <= mask_d;
         wdata_q  <= wdata_d;
         vld_q    <= vld_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         mis_q    <= mis_d;
      end
   end

   // Per-entry overlap with the probing load; includes the entry leaving this cycle.
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++)
         hit[i] = vld_q[i] & (addr_q[i] == ld_addr[ADDR_W-1:DW_OFF_W]) & (|(mask_q[i] & ld_mask));
   end

`ifdef LSU_STORE_FWD_EN
   logic        fwd_hit, fwd_cov;
   logic [63:0] fwd_data;

   // Walk oldest to youngest so the youngest overlapping entry decides.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_cov  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (hit[rd_ptr_q + PTR_W'(i)]) begin
            fwd_hit  = 1'b1;
            fwd_cov  = ((mask_q[rd_ptr_q + PTR_W'(i)] & ld_mask) == ld_mask);
            fwd_data = wdata_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end

   assign ld_fwd_valid = ld_valid & fwd_hit & fwd_cov;
   assign ld_fwd_data  = ld_fwd_valid ? fwd_data : '0;
   assign ld_hazard    = ld_valid & fwd_hit & !fwd_cov;
`else
   assign ld_hazard    = ld_valid & (|hit);
   assign ld_fwd_valid = 1'b0;
   assign ld_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_lsu_store_buf.sv
// Bench for lsu_store_buf: reset checks, a table of single-store alignment
// vectors, directed multi-cycle sequences, and randomized traffic checked
// every cycle against a queue-based reference model.
module tb_lsu_store_buf;

   localparam int DEPTH = 4;
   localparam int AW    = 64;

   logic          clk;
   logic          rst_n;
   logic          st_valid, st_ready, st_misalign;
   logic [AW-1:0] st_addr;
   logic [63:0]   st_data;
   logic [3:0]    st_size;
   logic          ld_busy, ld_valid, ld_hazard, ld_fwd_valid;
   logic [AW-1:0] ld_addr;
   logic [3:0]    ld_size;
   logic [63:0]   ld_fwd_data;
   logic          data_sram_en, data_sram_ready, sb_empty;
   logic [7:0]    data_sram_we;
   logic [AW-1:0] data_sram_addr;
   logic [63:0]   data_sram_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   lsu_store_buf #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_size(st_size), .st_misalign(st_misalign),
      .ld_busy(ld_busy), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_hazard(ld_hazard), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
      .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .data_sram_ready(data_sram_ready), .sb_empty(sb_empty)
   );

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct { logic [63:0] dw; logic [7:0] mask; logic [63:0] wdata; } ent_t;
   ent_t q[$];
   logic exp_mis;

   typedef struct {
      logic [3:0] size; logic [63:0] addr; logic [63:0] data;
      logic mis; logic [7:0] we; logic [63:0] wdata;
   } vec_t;
   vec_t tbl[10];

   // Reference rules: access width in bytes, natural alignment, lane mask, replication.
   function automatic int nbytes(input logic [3:0] s);
      case (s)
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0100: return 4;
         4'b1000: return 8;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_aligned(input logic [3:0] s, input logic [2:0] off);
      int n;
      n = nbytes(s);
      return (n != 0) && ((int'(off) % n) == 0);
   endfunction

   function automatic logic [7:0] m_mask(input logic [3:0] s, input logic [2:0] off);
      int v;
      v = ((1 << nbytes(s)) - 1) << off;
      return v[7:0];
   endfunction

   function automatic logic [63:0] m_lane(input logic [3:0] s, input logic [63:0] d);
      logic [63:0] r;
      int n;
      r = '0;
      n = nbytes(s);
      if (n == 0) return r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Compare every output with the model, then advance the model over the coming edge.
   task automatic tick();
      bit          en, acc, hz, fv;
      logic [7:0]  lm;
      logic [63:0] fd, we_e, ad_e, wd_e;
      int          y;
      ent_t        e;
      en   = (q.size() > 0) && !ld_busy;
      we_e = '0; ad_e = '0; wd_e = '0;
      if (en) begin
         we_e = 64'(q[0].mask); ad_e = q[0].dw; wd_e = q[0].wdata;
      end
      chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
      chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
      chk("st_misalign", 64'(st_misalign), 64'(exp_mis));
      chk("sram_en", 64'(data_sram_en), 64'(en));
      chk("sram_we", 64'(data_sram_we), we_e);
      chk("sram_addr", data_sram_addr, ad_e);
      chk("sram_wdata", data_sram_wdata, wd_e);
      lm = m_mask(ld_size, ld_addr[2:0]);
      y  = -1;
      for (int i = 0; i < q.size(); i++)
         if (ld_valid && q[i].dw == (ld_addr & ~64'h7) && (q[i].mask & lm) != 8'h00) y = i;
      hz = 0; fv = 0; fd = '0;
`ifdef LSU_STORE_FWD_EN
      if (y >= 0) begin
         if ((q[y].mask & lm) == lm) begin
            fv = 1; fd = q[y].wdata;
         end else hz = 1;
      end
`else
      hz = (y >= 0);
`endif
      chk("ld_hazard", 64'(ld_hazard), 64'(hz));
      chk("ld_fwd_valid", 64'(ld_fwd_valid), 64'(fv));
      chk("ld_fwd_data", ld_fwd_data, fd);
      if (!rst_n) begin
         q.delete();
         exp_mis = 1'b0;
      end else begin
         acc = st_valid && (q.size() < DEPTH) && m_aligned(st_size, st_addr[2:0]);
         e.dw = st_addr & ~64'h7;
         e.mask = m_mask(st_size, st_addr[2:0]);
         e.wdata = m_lane(st_size, st_data);
         if (en && data_sram_ready) void'(q.pop_front());
         if (acc) q.push_back(e);
         exp_mis = st_valid && !m_aligned(st_size, st_addr[2:0]);
      end
      @(negedge clk);
   endtask

   task automatic drive_st(input logic v, input logic [3:0] s, input logic [63:0] a, input logic [63:0] d);
      st_valid = v; st_size = s; st_addr = a; st_data = d;
   endtask

   initial begin
      tbl[0] = '{4'b0010, 64'h1002, 64'hABCD,             1'b0, 8'h0C, 64'hABCDABCDABCDABCD};
      tbl[1] = '{4'b0001, 64'h1007, 64'h1122334455667788, 1'b0, 8'h80, 64'h8888888888888888};
      tbl[2] = '{4'b0100, 64'h2004, 64'h1122334455667788, 1'b0, 8'hF0, 64'h5566778855667788};
      tbl[3] = '{4'b1000, 64'h3000, 64'h0123456789ABCDEF, 1'b0, 8'hFF, 64'h0123456789ABCDEF};
      tbl[4] = '{4'b0010, 64'h1006, 64'hBEEF,             1'b0, 8'hC0, 64'hBEEFBEEFBEEFBEEF};
      tbl[5] = '{4'b0100, 64'h2006, 64'h1234,             1'b1, 8'h00, 64'h0};
      tbl[6] = '{4'b0010, 64'h1001, 64'h1234,             1'b1, 8'h00, 64'h0};
      tbl[7] = '{4'b1000, 64'h3004, 64'h1234,             1'b1, 8'h00, 64'h0};
      tbl[8] = '{4'b0011, 64'h1000, 64'h1234,             1'b1, 8'h00, 64'h0};
      tbl[9] = '{4'b0000, 64'h1000, 64'h1234,             1'b1, 8'h00, 64'h0};

      rst_n = 1'b0; exp_mis = 1'b0;
      drive_st(1'b0, 4'b0001, '0, '0);
      ld_busy = 0; ld_valid = 0; ld_addr = '0; ld_size = 4'b0001; data_sram_ready = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; #1;
      chk("rst_st_ready", 64'(st_ready), 64'd1);
      chk("rst_sb_empty", 64'(sb_empty), 64'd1);
      chk("rst_en", 64'(data_sram_en), 64'd0);
      chk("rst_we", 64'(data_sram_we), 64'd0);
      chk("rst_wdata", data_sram_wdata, 64'd0);
      chk("rst_mis", 64'(st_misalign), 64'd0);
      chk("rst_hazard", 64'(ld_hazard), 64'd0);
      tick();

      // Single-store alignment table.
      foreach (tbl[i]) begin
         drive_st(1'b1, tbl[i].size, tbl[i].addr, tbl[i].data); #1; tick();
         st_valid = 1'b0; #1;
         chk($sformatf("tbl%0d_mis", i), 64'(st_misalign), 64'(tbl[i].mis));
         chk($sformatf("tbl%0d_en", i), 64'(data_sram_en), 64'(!tbl[i].mis));
         chk($sformatf("tbl%0d_we", i), 64'(data_sram_we), 64'(tbl[i].we));
         chk($sformatf("tbl%0d_addr", i), data_sram_addr, tbl[i].mis ? 64'h0 : (tbl[i].addr & ~64'h7));
         chk($sformatf("tbl%0d_wdata", i), data_sram_wdata, tbl[i].wdata);
         tick();
         #1;
         chk($sformatf("tbl%0d_mis_clr", i), 64'(st_misalign), 64'd0);
         chk($sformatf("tbl%0d_empty", i), 64'(sb_empty), 64'd1);
         tick();
      end

      // Fill to full with SRAM stalled, then drain in order.
      data_sram_ready = 0;
      for (int i = 0; i < 5; i++) begin
         drive_st(1'b1, 4'b1000, 64'h5000 + 64'(8*i), 64'h100 + 64'(i)); #1;
         chk($sformatf("full_rdy%0d", i), 64'(st_ready), 64'(i < 4));
         tick();
      end
      st_valid = 1'b0; data_sram_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("drain%0d_en", i), 64'(data_sram_en), 64'd1);
         chk($sformatf("drain%0d_addr", i), data_sram_addr, 64'h5000 + 64'(8*i));
         chk($sformatf("drain%0d_wdata", i), data_sram_wdata, 64'h100 + 64'(i));
         tick();
      end
      #1; chk("drain_empty", 64'(sb_empty), 64'd1); tick();

      // Load holds the port: no drain until it lets go, then head first.
      ld_busy = 1;
      drive_st(1'b1, 4'b0001, 64'h6000, 64'h11); #1; tick();
      drive_st(1'b1, 4'b0001, 64'h6009, 64'h22); #1; tick();
      st_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1; chk($sformatf("busy%0d_en", i), 64'(data_sram_en), 64'd0); tick();
      end
      ld_busy = 0; #1;
      chk("busy_head_addr", data_sram_addr, 64'h6000);
      chk("busy_head_we", 64'(data_sram_we), 64'h01);
      tick(); #1;
      chk("busy_next_addr", data_sram_addr, 64'h6008);
      chk("busy_next_we", 64'(data_sram_we), 64'h02);
      tick();

      // Load probe against a buffered doubleword store.
      ld_busy = 1;
      drive_st(1'b1, 4'b1000, 64'h3000, 64'hCAFEF00D12345678); #1; tick();
      st_valid = 1'b0; ld_valid = 1; ld_size = 4'b0100; ld_addr = 64'h3004; #1;
`ifdef LSU_STORE_FWD_EN
      chk("fwd_valid", 64'(ld_fwd_valid), 64'd1);
      chk("fwd_hazard", 64'(ld_hazard), 64'd0);
      chk("fwd_data", ld_fwd_data, 64'hCAFEF00D12345678);
`else
      chk("hz_overlap", 64'(ld_hazard), 64'd1);
      chk("hz_fwd_valid", 64'(ld_fwd_valid), 64'd0);
`endif
      tick();
      ld_addr = 64'h3008; #1;
      chk("hz_other_dw", 64'(ld_hazard), 64'd0);
      tick();
      ld_valid = 0; ld_busy = 0; #1; tick();

      // Reset while draining.
      data_sram_ready = 0;
      for (int i = 0; i < 3; i++) begin
         drive_st(1'b1, 4'b0010, 64'h7000 + 64'(2*i), 64'(i)); #1; tick();
      end
      st_valid = 1'b0; #1;
      chk("prerst_en", 64'(data_sram_en), 64'd1);
      tick();
      rst_n = 1'b0; #1; tick();
      rst_n = 1'b1; #1;
      chk("postrst_en", 64'(data_sram_en), 64'd0);
      chk("postrst_empty", 64'(sb_empty), 64'd1);
      chk("postrst_ready", 64'(st_ready), 64'd1);
      tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         int r, n;
         r = $urandom_range(0, 15);
         st_valid = 1'($urandom_range(0, 1));
         st_size = 4'b0001 << $urandom_range(0, 3);
         n = nbytes(st_size);
         st_addr = 64'h4000 + 64'(8 * $urandom_range(0, 3)) + 64'(n * $urandom_range(0, 8 / n - 1));
         if (r == 0) st_addr[2:0] = 3'($urandom_range(0, 7));
         if (r == 1) st_size = 4'($urandom_range(0, 15));
         st_data = {$urandom, $urandom};
         ld_busy = ($urandom_range(0, 3) == 0);
         data_sram_ready = ($urandom_range(0, 2) != 0);
         ld_valid = 1'($urandom_range(0, 1));
         ld_size = 4'b0001 << $urandom_range(0, 3);
         n = nbytes(ld_size);
         ld_addr = 64'h4000 + 64'(8 * $urandom_range(0, 3)) + 64'(n * $urandom_range(0, 8 / n - 1));
         rst_n = (c % 197 != 150);
         #1; tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
